// File: rtl/pwm_capture.sv
// PWM receive monitor: measures high time and period of each PWM cycle,
// flags a stalled line and decodes the forward/reverse direction lines.
module pwm_capture #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_pwm_in,
  input  logic [1:0]       i_dir_in,
  output logic [CNT_W-1:0] o_high_cnt,
  output logic [CNT_W-1:0] o_period_cnt,
  output logic             o_meas_valid,
  output logic             o_meas_ovf,
  output logic             o_stalled,
  output logic             o_stall_level,
  output logic [1:0]       o_dir_state,
  output logic             o_dir_fault
);

  localparam int unsigned      TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [TO_W-1:0]  TO_SAT  = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_MEAS = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_pwm_meta, r_pwm_s, r_pwm_d, r_rise;
  logic [1:0]       r_dir_meta, r_dir_s, r_dir_state;
  logic             r_dir_fault;
  logic [TO_W-1:0]  r_to_cnt, w_to_nxt;
  logic [CNT_W-1:0] r_per_run, w_per_run_nxt, r_hi_run, w_hi_run_nxt;
  logic             r_ovf_run, w_ovf_run_nxt;
  logic [CNT_W-1:0] r_high_cnt, w_high_cnt_nxt, r_period_cnt, w_period_cnt_nxt;
  logic             r_meas_valid, w_meas_valid_nxt, r_meas_ovf, w_meas_ovf_nxt;
  logic             r_stalled, w_stalled_nxt, r_stall_level, w_stall_level_nxt;
  logic             w_timeout;

  // Synchronisers, registered edge detect and direction decode.
  // r_pwm_d is the level aligned with r_rise, so it feeds the high counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pwm_meta  <= 1'b0;
      r_pwm_s     <= 1'b0;
      r_pwm_d     <= 1'b0;
      r_rise      <= 1'b0;
      r_dir_meta  <= 2'b00;
      r_dir_s     <= 2'b00;
      r_dir_state <= 2'b00;
      r_dir_fault <= 1'b0;
    end else begin
      r_pwm_meta  <= i_pwm_in;
      r_pwm_s     <= r_pwm_meta;
      r_pwm_d     <= r_pwm_s;
      r_rise      <= r_pwm_s & ~r_pwm_d;
      r_dir_meta  <= i_dir_in;
      r_dir_s     <= r_dir_meta;
      r_dir_state <= r_dir_s;
      r_dir_fault <= &r_dir_s;
    end
  end

  // Measurement FSM state and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_to_cnt      <= '0;
      r_per_run     <= '0;
      r_hi_run      <= '0;
      r_ovf_run     <= 1'b0;
      r_high_cnt    <= '0;
      r_period_cnt  <= '0;
      r_meas_valid  <= 1'b0;
      r_meas_ovf    <= 1'b0;
      r_stalled     <= 1'b0;
      r_stall_level <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_to_cnt      <= w_to_nxt;
      r_per_run     <= w_per_run_nxt;
      r_hi_run      <= w_hi_run_nxt;
      r_ovf_run     <= w_ovf_run_nxt;
      r_high_cnt    <= w_high_cnt_nxt;
      r_period_cnt  <= w_period_cnt_nxt;
      r_meas_valid  <= w_meas_valid_nxt;
      r_meas_ovf    <= w_meas_ovf_nxt;
      r_stalled     <= w_stalled_nxt;
      r_stall_level <= w_stall_level_nxt;
    end
  end

  // A rise in the same cycle as the timeout wins.
  assign w_timeout = ~r_rise & (r_to_cnt == TO_LAST);

  always_comb begin
    w_state_nxt       = r_state;
    w_to_nxt          = r_to_cnt;
    w_per_run_nxt     = r_per_run;
    w_hi_run_nxt      = r_hi_run;
    w_ovf_run_nxt     = r_ovf_run;
    w_high_cnt_nxt    = r_high_cnt;
    w_period_cnt_nxt  = r_period_cnt;
    w_meas_valid_nxt  = 1'b0;
    w_meas_ovf_nxt    = r_meas_ovf;
    w_stalled_nxt     = r_stalled;
    w_stall_level_nxt = r_stall_level;

    if (r_rise) begin
      w_to_nxt = '0;
    end else if (r_to_cnt != TO_SAT) begin
      w_to_nxt = r_to_cnt + TO_W'(1);
    end

    case (r_state)
      ST_IDLE: begin
        if (r_rise) begin
          w_state_nxt   = ST_MEAS;
          w_per_run_nxt = CNT_ONE;
          w_hi_run_nxt  = CNT_ONE;
          w_ovf_run_nxt = 1'b0;
          w_stalled_nxt = 1'b0;
        end
      end
      ST_MEAS: begin
        if (r_rise) begin
          w_period_cnt_nxt = r_per_run;
          w_high_cnt_nxt   = r_hi_run;
          w_meas_ovf_nxt   = r_ovf_run;
          w_meas_valid_nxt = 1'b1;
          w_per_run_nxt    = CNT_ONE;
          w_hi_run_nxt     = CNT_ONE;
          w_ovf_run_nxt    = 1'b0;
        end else begin
          if (r_per_run == CNT_MAX) begin
            w_ovf_run_nxt = 1'b1;
          end else begin
            w_per_run_nxt = r_per_run + CNT_ONE;
          end
          if (r_pwm_d) begin
            if (r_hi_run == CNT_MAX) begin
              w_ovf_run_nxt = 1'b1;
            end else begin
              w_hi_run_nxt = r_hi_run + CNT_ONE;
            end
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Stall drops back to IDLE; last results are kept.
    if (w_timeout) begin
      w_state_nxt       = ST_IDLE;
      w_stalled_nxt     = 1'b1;
      w_stall_level_nxt = r_pwm_s;
      w_per_run_nxt     = '0;
      w_hi_run_nxt      = '0;
      w_ovf_run_nxt     = 1'b0;
    end
  end

  assign o_high_cnt    = r_high_cnt;
  assign o_period_cnt  = r_period_cnt;
  assign o_meas_valid  = r_meas_valid;
  assign o_meas_ovf    = r_meas_ovf;
  assign o_stalled     = r_stalled;
  assign o_stall_level = r_stall_level;
  assign o_dir_state   = r_dir_state;
  assign o_dir_fault   = r_dir_fault;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: 16-bit and 4-bit instances share stimulus and are
// compared every cycle against a sample-history model plus literal checks.
module tb_pwm_capture;

  localparam int TIMEOUT = 1024;
  localparam int DEPTH   = 4096;

  logic        clk;
  logic        rst_n;
  logic        pwm;
  logic [1:0]  dir;

  logic [15:0] hi16, per16;
  logic        v16, ovf16, st16, sl16, df16;
  logic [1:0]  ds16;
  logic [3:0]  hi4, per4;
  logic        v4, ovf4, st4, sl4, df4;
  logic [1:0]  ds4;

  pwm_capture #(.CNT_W(16), .TIMEOUT(TIMEOUT)) dut16 (
    .clk(clk), .rst_n(rst_n), .i_pwm_in(pwm), .i_dir_in(dir),
    .o_high_cnt(hi16), .o_period_cnt(per16), .o_meas_valid(v16),
    .o_meas_ovf(ovf16), .o_stalled(st16), .o_stall_level(sl16),
    .o_dir_state(ds16), .o_dir_fault(df16)
  );

  pwm_capture #(.CNT_W(4), .TIMEOUT(TIMEOUT)) dut4 (
    .clk(clk), .rst_n(rst_n), .i_pwm_in(pwm), .i_dir_in(dir),
    .o_high_cnt(hi4), .o_period_cnt(per4), .o_meas_valid(v4),
    .o_meas_ovf(ovf4), .o_stalled(st4), .o_stall_level(sl4),
    .o_dir_state(ds4), .o_dir_fault(df4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clip(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Model: keeps the pwm/dir value sampled at every posedge since reset.
  // Outputs after edge n reflect samples up to n-3 (pwm) and n-2 (dir).
  bit         samp [DEPTH];
  logic [1:0] dsamp[DEPTH];
  int  n, last_rise, to_ref, m, p_len, h_len;
  bit  armed, running;
  bit  e_valid, e_stalled, e_slev, e_ovf16, e_ovf4;
  int  e_hi16, e_per16, e_hi4, e_per4;
  logic [1:0] e_dir;

  initial begin
    running = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        n = 0; samp[0] = 1'b0; dsamp[0] = 2'b00;
        armed = 1'b0; last_rise = 0; to_ref = -3;
        e_valid = 1'b0; e_stalled = 1'b0; e_slev = 1'b0;
        e_ovf16 = 1'b0; e_ovf4 = 1'b0;
        e_hi16 = 0; e_per16 = 0; e_hi4 = 0; e_per4 = 0;
        e_dir = 2'b00;
        running = 1'b1;
      end else begin
        n++;
        if (n >= DEPTH) begin
          $display("FAIL model_depth: got %0d, expected below %0d", n, DEPTH);
          $fatal(1, "model history exhausted");
        end
        samp[n]  = pwm;
        dsamp[n] = dir;
        m = n - 3;
        e_valid = 1'b0;
        if (m >= 1 && samp[m] && !samp[m-1]) begin
          if (armed) begin
            p_len = m - last_rise;
            h_len = 0;
            for (int i = last_rise; i < m; i++) h_len += int'(samp[i]);
            e_per16 = clip(p_len, 65535); e_hi16 = clip(h_len, 65535);
            e_ovf16 = (p_len > 65535);
            e_per4  = clip(p_len, 15);    e_hi4  = clip(h_len, 15);
            e_ovf4  = (p_len > 15);
            e_valid = 1'b1;
          end
          armed = 1'b1; last_rise = m; to_ref = m; e_stalled = 1'b0;
        end else if (m - to_ref == TIMEOUT) begin
          e_stalled = 1'b1; e_slev = samp[m+1]; armed = 1'b0;
        end
        e_dir = (n >= 2) ? dsamp[n-2] : 2'b00;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (running) begin
        check("valid16",  32'(v16),   32'(e_valid));
        check("high16",   32'(hi16),  32'(e_hi16));
        check("period16", 32'(per16), 32'(e_per16));
        check("ovf16",    32'(ovf16), 32'(e_ovf16));
        check("stall16",  32'(st16),  32'(e_stalled));
        check("slev16",   32'(sl16),  32'(e_slev));
        check("dir16",    32'(ds16),  32'(e_dir));
        check("fault16",  32'(df16),  32'(e_dir == 2'b11));
        check("valid4",   32'(v4),    32'(e_valid));
        check("high4",    32'(hi4),   32'(e_hi4));
        check("period4",  32'(per4),  32'(e_per4));
        check("ovf4",     32'(ovf4),  32'(e_ovf4));
        check("stall4",   32'(st4),   32'(e_stalled));
        check("dir4",     32'(ds4),   32'(e_dir));
        if (v16 === 1'b1) pulses++;
      end
    end
  end

  task automatic drive(input logic v);
    pwm = v;
    @(posedge clk);
    #1;
  endtask

  task automatic run_pwm(input int hi, input int per, input int cnt);
    for (int k = 0; k < cnt; k++)
      for (int c = 0; c < per; c++) drive(c < hi);
  endtask

  logic [1:0] dir_vec   [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic       fault_vec [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    rst_n = 1'b0; pwm = 1'b0; dir = 2'b00;
    // Reset held with pwm toggling
    for (int i = 0; i < 8; i++) drive(i[0]);
    drive(1'b0); drive(1'b0);
    check("rst_pulses", 32'(pulses), 32'd0);
    check("rst_high",   32'(hi16),   32'd0);
    check("rst_period", 32'(per16),  32'd0);
    check("rst_stall",  32'(st16),   32'd0);
    rst_n = 1'b1;

    // Period 11 high 4: first rise gives no pulse
    pulses = 0;
    run_pwm(4, 11, 6);
    check("p11h4_pulses", 32'(pulses), 32'd5);
    check("p11h4_high",   32'(hi16),   32'd4);
    check("p11h4_period", 32'(per16),  32'd11);
    check("p11h4_ovf",    32'(ovf16),  32'd0);

    // Duty change to 8 mid-stream
    pulses = 0;
    run_pwm(8, 11, 4);
    check("p11h8_pulses", 32'(pulses), 32'd4);
    check("p11h8_high",   32'(hi16),   32'd8);
    check("p11h8_period", 32'(per16),  32'd11);

    // Line stuck high -> stall, results retained
    pulses = 0;
    for (int i = 0; i < 1100; i++) drive(1'b1);
    check("stall_flag",   32'(st16),   32'd1);
    check("stall_level",  32'(sl16),   32'd1);
    check("stall_high",   32'(hi16),   32'd8);
    check("stall_pulses", 32'(pulses), 32'd1);

    // Recovery: first rise clears stall, pulse on second
    pulses = 0;
    for (int i = 0; i < 5; i++) drive(1'b0);
    run_pwm(4, 11, 1);
    check("recov_stall",   32'(st16),   32'd0);
    check("recov_pulses1", 32'(pulses), 32'd0);
    run_pwm(4, 11, 2);
    check("recov_pulses2", 32'(pulses), 32'd2);
    check("recov_high",    32'(hi16),   32'd4);

    // Period 20 high 18: saturates the 4-bit instance only
    run_pwm(18, 20, 3);
    check("sat4_high",    32'(hi4),   32'd15);
    check("sat4_period",  32'(per4),  32'd15);
    check("sat4_ovf",     32'(ovf4),  32'd1);
    check("sat16_high",   32'(hi16),  32'd18);
    check("sat16_period", 32'(per16), 32'd20);
    check("sat16_ovf",    32'(ovf16), 32'd0);

    // Direction decode, 3-cycle latency
    for (int i = 0; i < 4; i++) begin
      dir = dir_vec[i];
      repeat (3) @(posedge clk);
      #1;
      check("dir_state", 32'(ds16), 32'(dir_vec[i]));
      check("dir_fault", 32'(df16), 32'(fault_vec[i]));
    end
    dir = 2'b00;

    // Reset pulse mid-period discards the partial measurement
    run_pwm(4, 11, 2);
    drive(1'b1); drive(1'b1); drive(1'b1); drive(1'b1); drive(1'b0);
    rst_n = 1'b0;
    drive(1'b0);
    check("mid_rst_high",   32'(hi16),  32'd0);
    check("mid_rst_period", 32'(per16), 32'd0);
    check("mid_rst_dir",    32'(ds16),  32'd0);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) drive(1'b0);
    run_pwm(4, 11, 3);
    check("post_rst_pulses", 32'(pulses), 32'd2);
    check("post_rst_high",   32'(hi16),   32'd4);
    check("post_rst_period", 32'(per16),  32'd11);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
